multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS-subset datapath: addi, beq, bne, j, jal, jr.
- It replaces single-cycle combinational control with a registered state machine. It steps each instruction through fetch, decode, execute and writeback over several clocks.
- It drives the same datapath select signals as the existing control path, plus IR/PC write strobes, a fetch handshake and a retired-instruction counter.
- It sits between the instruction register / instruction memory port and the shared PC, register-file, ALU and write-back muxes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode field from instruction register (IR)
- func  in  6  function field from IR
- Zero  in  1  ALU zero flag (combinational, valid in EX)
- imem_ready  in  1  instruction memory has fetch data on its output this cycle
- imem_req  out  1  fetch request, held until imem_ready
- IR_Write  out  1  load IR this edge
- PC_Write  out  1  load PC from the PC_s-selected source this edge
- PC_s  out  2  00 = PC+4, 01 = rs data (jr), 10 = branch target, 11 = jump target
- ALU_OP  out  3  000 = add, 001 = sub
- imm_s  out  1  ALU B operand: 0 = rt data, 1 = sign-extended immediate
- w_r_s  out  2  destination register: 00 = rd, 01 = rt, 11 = $31
- wr_data_s1, wr_data_s0  out  1 each  write-data select: {1,0} = PC+4, {0,0} = ALU result
- Write_Reg  out  1  register-file write enable
- Mem_Write  out  1  constant 0 (no stores implemented)
- instr_done  out  1  one-cycle pulse on the retiring cycle of each instruction
- illegal  out  1  sticky: unsupported op/func decoded
- instret  out  CNT_W  retired-instruction count

## Operation
- States: RST, IF, ID, EX, WB, ERR. The state is registered; all outputs are combinational from the state plus op, func and Zero.
- Default in every state: every output is 0 except as listed below.
- RST: entered asynchronously while rst_n = 0; all outputs 0, instret = 0. Next state is IF unconditionally.
- IF: imem_req = 1.
  - imem_ready = 1 → IR_Write = 1, next state ID.
  - imem_ready = 0 → stay in IF.
- ID: decode op and func.
  - j: PC_Write = 1, PC_s = 11; retire; next IF.
  - jr (op 000000, func 001000): PC_Write = 1, PC_s = 01; retire; next IF.
  - jal: Write_Reg = 1, w_r_s = 11, wr_data = {1,0}, PC_Write = 1, PC_s = 11, all in the same cycle. $31 receives the old PC+4 because the PC updates on the same edge. Retire; next IF.
  - beq, bne, addi: next EX.
  - Anything else: next ERR, no write strobes.
- EX:
  - beq/bne: imm_s = 0, ALU_OP = 001, PC_Write = 1. PC_s = 10 if taken (beq: Zero = 1; bne: Zero = 0), else 00. Retire; next IF.
  - addi: imm_s = 1, ALU_OP = 000. The ALU result is captured into the datapath ALUOut register. Next WB.
- WB (addi only):
  - Write_Reg = 1, w_r_s = 01, wr_data = {0,0}.
  - PC_Write = 1, PC_s = 00.
  - Retire; next IF.
- ERR: illegal = 1; all strobes 0. Exit only via rst_n.
- Retire means instr_done = 1 and instret increments by 1 on that edge. instret wraps modulo 2^CNT_W with no flag.
- op and func are read only in ID, EX and WB. IR_Write is asserted only in IF, so they are stable there.

## Timing
- Minimum latency from an IF cycle with imem_ready = 1 to retirement:
  - j, jr, jal: 2 cycles.
  - beq, bne: 3 cycles.
  - addi: 4 cycles.
- Each IF wait cycle (imem_ready = 0) adds one cycle.
- At most one PC_Write and one Write_Reg per instruction. They never occur in IF.
- imem_ready arriving outside IF is ignored.
- rst_n low mid-instruction: state goes to RST immediately (asynchronously) and all outputs go to 0 in the same cycle. Any in-flight instruction is discarded without PC or register update. instret clears.
- The first clock edge after rst_n rises moves the state RST → IF, so imem_req rises one cycle after reset release.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state enum;
  - opcode constants: OP_RTYPE 000000, OP_BEQ 000100, OP_BNE 000101, OP_J 000010, OP_JAL 000011, OP_ADDI 001000;
  - FUNC_JR 001000;
  - PC_s, ALU_OP, w_r_s and write-data select codes.
- One sub-module, `instr_class_decode`: combinational map from op/func to a one-hot class (JMP, JR, JAL, BR_EQ, BR_NE, ADDI, ILLEGAL).
- The FSM and instret counter live in the top.

## Test plan
- Reset release, imem_ready held 0 for 3 cycles then 1:
  - imem_req = 1 from cycle 1 after release, 0 during reset;
  - IR_Write exactly once, on the ready cycle.
- addi (op 001000), imem_ready = 1 immediately:
  - ALU_OP = 000 and imm_s = 1 in EX;
  - in WB, Write_Reg = 1, w_r_s = 01, PC_s = 00;
  - instr_done on cycle 4; instret 0 → 1.
- beq with Zero = 1, then beq with Zero = 0:
  - PC_s = 10 then 00;
  - PC_Write = 1 and Write_Reg = 0 both times;
  - 3 cycles each.
- bne with Zero = 0 → PC_s = 10. jal → in ID, Write_Reg = 1, w_r_s = 11, {wr_data_s1, wr_data_s0} = 10, PC_s = 11. jr → PC_s = 01. Each retires in 2 cycles.
- op 100011 (unsupported) → ERR: illegal = 1, sticky through 10 cycles of imem_ready = 1, no PC_Write, instret unchanged. rst_n pulse → illegal = 0.
- rst_n asserted during EX of addi → no Write_Reg or PC_Write ever asserted; instret = 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST = 3'd0,
    ST_IF  = 3'd1,
    ST_ID  = 3'd2,
    ST_EX  = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_RS  = 2'b01;
  localparam logic [1:0] PCS_BR  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] WRS_RD = 2'b00;
  localparam logic [1:0] WRS_RT = 2'b01;
  localparam logic [1:0] WRS_RA = 2'b11;

  // {wr_data_s1, wr_data_s0}
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // Exactly one field is set for any op/func combination.
  typedef struct packed {
    logic jmp;
    logic jr;
    logic jal;
    logic br_eq;
    logic br_ne;
    logic addi;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational op/func to one-hot instruction class map.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   func_i,
  output instr_class_t cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_J:     cls_o.jmp   = 1'b1;
      OP_JAL:   cls_o.jal   = 1'b1;
      OP_BEQ:   cls_o.br_eq = 1'b1;
      OP_BNE:   cls_o.br_ne = 1'b1;
      OP_ADDI:  cls_o.addi  = 1'b1;
      OP_RTYPE: begin
        if (func_i == FUNC_JR) cls_o.jr      = 1'b1;
        else                   cls_o.illegal = 1'b1;
      end
      default:  cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Registered multi-cycle control FSM (IF/ID/EX/WB) with retired-instruction counter.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             Zero,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic [1:0]       PC_s,
  output logic [2:0]       ALU_OP,
  output logic             imm_s,
  output logic [1:0]       w_r_s,
  output logic             wr_data_s1,
  output logic             wr_data_s0,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output state_e           state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic [1:0]       wd_sel;
  instr_class_t     cls;

  instr_class_decode u_dec (
    .op_i   (op),
    .func_i (func),
    .cls_o  (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Fetch handshake: imem_req stays high in IF until imem_ready; the IF cycle
  // that sees both high loads IR on its closing edge. imem_ready is ignored
  // in every other state.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    PC_s       = PCS_PC4;
    ALU_OP     = ALU_ADD;
    imm_s      = 1'b0;
    w_r_s      = WRS_RD;
    wd_sel     = WD_ALU;
    Write_Reg  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IR_Write = 1'b1;
          state_d  = ST_ID;
        end
      end
      ST_ID: begin
        if (cls.jmp || cls.jr || cls.jal) begin
          PC_Write   = 1'b1;
          PC_s       = cls.jr ? PCS_RS : PCS_JMP;
          instr_done = 1'b1;
          state_d    = ST_IF;
          // $31 captures PC+4 on the same edge that the PC moves to the target.
          if (cls.jal) begin
            Write_Reg = 1'b1;
            w_r_s     = WRS_RA;
            wd_sel    = WD_PC4;
          end
        end else if (cls.br_eq || cls.br_ne || cls.addi) begin
          state_d = ST_EX;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_EX: begin
        if (cls.br_eq || cls.br_ne) begin
          ALU_OP     = ALU_SUB;
          PC_Write   = 1'b1;
          PC_s       = ((cls.br_eq && Zero) || (cls.br_ne && !Zero)) ? PCS_BR : PCS_PC4;
          instr_done = 1'b1;
          state_d    = ST_IF;
        end else if (cls.addi) begin
          imm_s   = 1'b1;
          state_d = ST_WB;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        Write_Reg  = 1'b1;
        w_r_s      = WRS_RT;
        wd_sel     = WD_ALU;
        PC_Write   = 1'b1;
        PC_s       = PCS_PC4;
        instr_done = 1'b1;
        state_d    = ST_IF;
      end
      ST_ERR: illegal = 1'b1;
      default: state_d = ST_ERR;
    endcase
  end

  assign {wr_data_s1, wr_data_s0} = wd_sel;
  assign Mem_Write = 1'b0;
  assign instret   = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction sequences with a retirement scoreboard.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam int W = 34;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = '0;
  logic [5:0]       func = '0;
  logic             Zero = 1'b0;
  logic             imem_ready = 1'b0;
  logic             imem_req, IR_Write, PC_Write, imm_s;
  logic [1:0]       PC_s, w_r_s;
  logic [2:0]       ALU_OP;
  logic             wr_data_s1, wr_data_s0, Write_Reg, Mem_Write;
  logic             instr_done, illegal;
  logic [CNT_W-1:0] instret;
  state_e           dbg_state;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [W-1:0] exp_q[$];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .Zero(Zero),
    .imem_ready(imem_ready), .imem_req(imem_req), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_s(PC_s), .ALU_OP(ALU_OP), .imm_s(imm_s),
    .w_r_s(w_r_s), .wr_data_s1(wr_data_s1), .wr_data_s0(wr_data_s0),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .instr_done(instr_done),
    .illegal(illegal), .instret(instret), .state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pcw"}, PC_Write, 0);
    chk({tag, "_wrg"}, Write_Reg, 0);
    chk({tag, "_irw"}, IR_Write, 0);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_done"}, instr_done, 0);
    chk({tag, "_memw"}, Mem_Write, 0);
  endtask

  // Release reset just after an edge; the next edge moves RST -> IF.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_state", dbg_state, ST_RST);
    chk_quiet("rel");
    chk("rel_instret", instret, 0);
    cyc();
    chk("rel_if_state", dbg_state, ST_IF);
    chk("rel_if_req", imem_req, 1);
    exp_instret = '0;
  endtask

  // Drives one instruction from the first IF cycle; lat counts IF..retire.
  task automatic run_instr(input string name, input int nwait, input logic [5:0] opv,
                           input logic [5:0] fnv, input logic zv, input int lat,
                           input logic [1:0] pcs, input logic wr, input logic [1:0] wrs,
                           input logic [1:0] wd);
    int irw = 0;
    int pcw = 0;
    int wrg = 0;
    logic [W-1:0] e = '0;
    for (int i = 0; i < nwait; i++) begin
      imem_ready = 1'b0;
      #1;
      chk({name, "_wait_req"}, imem_req, 1);
      chk({name, "_wait_pcw"}, PC_Write, 0);
      if (IR_Write) irw++;
      cyc();
    end
    imem_ready = 1'b1;
    #1;
    chk({name, "_irw_before_ready"}, irw, 0);
    chk({name, "_irw_ready"}, IR_Write, 1);
    chk({name, "_if_pcw"}, PC_Write, 0);
    chk({name, "_if_wrg"}, Write_Reg, 0);
    exp_instret = exp_instret + 1;
    exp_q.push_back({pcs, exp_instret});
    cyc();
    op = opv;
    func = fnv;
    Zero = zv;
    for (int c = 1; c < lat; c++) begin
      imem_ready = 1'($urandom_range(0, 1));
      #1;
      if (PC_Write) pcw++;
      if (Write_Reg) wrg++;
      chk({name, "_irw_late"}, IR_Write, 0);
      chk({name, "_req_late"}, imem_req, 0);
      if (c < lat - 1) begin
        chk({name, "_done_early"}, instr_done, 0);
      end else begin
        chk({name, "_done"}, instr_done, 1);
        e = exp_q.pop_front();
        chk({name, "_pcs"}, PC_s, e[W-1:W-2]);
        if (wr) begin
          chk({name, "_wrs"}, w_r_s, wrs);
          chk({name, "_wd"}, {wr_data_s1, wr_data_s0}, wd);
        end
      end
      if (opv == OP_ADDI && c == 2) begin
        chk({name, "_ex_alu"}, ALU_OP, ALU_ADD);
        chk({name, "_ex_imm"}, imm_s, 1);
      end
      if ((opv == OP_BEQ || opv == OP_BNE) && c == 2) begin
        chk({name, "_ex_alu"}, ALU_OP, ALU_SUB);
        chk({name, "_ex_imm"}, imm_s, 0);
      end
      cyc();
    end
    chk({name, "_instret"}, instret, e[CNT_W-1:0]);
    chk({name, "_pcw_count"}, pcw, 1);
    chk({name, "_wrg_count"}, wrg, wr ? 1 : 0);
    chk({name, "_back_to_if"}, dbg_state, ST_IF);
    imem_ready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, ST_RST);
    chk_quiet("rst");
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);
    release_reset();

    // first fetch waits 3 cycles; addi retires on cycle 4
    run_instr("addi_w3", 3, OP_ADDI, 6'h00, 1'b0, 4, PCS_PC4, 1'b1, WRS_RT, WD_ALU);
    run_instr("addi",    0, OP_ADDI, 6'h15, 1'b1, 4, PCS_PC4, 1'b1, WRS_RT, WD_ALU);
    run_instr("beq_t",   0, OP_BEQ,  6'h00, 1'b1, 3, PCS_BR,  1'b0, WRS_RD, WD_ALU);
    run_instr("beq_nt",  0, OP_BEQ,  6'h00, 1'b0, 3, PCS_PC4, 1'b0, WRS_RD, WD_ALU);
    run_instr("bne_t",   $urandom_range(0, 2), OP_BNE, 6'h00, 1'b0, 3, PCS_BR,  1'b0, WRS_RD, WD_ALU);
    run_instr("bne_nt",  $urandom_range(0, 2), OP_BNE, 6'h00, 1'b1, 3, PCS_PC4, 1'b0, WRS_RD, WD_ALU);
    run_instr("j",       0, OP_J,    6'h3f, 1'b0, 2, PCS_JMP, 1'b0, WRS_RD, WD_ALU);
    run_instr("jal",     $urandom_range(0, 2), OP_JAL, 6'h00, 1'b1, 2, PCS_JMP, 1'b1, WRS_RA, WD_PC4);
    run_instr("jr",      0, OP_RTYPE, FUNC_JR, 1'b0, 2, PCS_RS, 1'b0, WRS_RD, WD_ALU);
    chk("sb_empty", exp_q.size(), 0);

    // unsupported opcode: sticky ERR, no strobes, counter frozen
    imem_ready = 1'b1;
    #1;
    chk("ill_irw", IR_Write, 1);
    cyc();
    op = 6'b100011;
    func = 6'h00;
    #1;
    chk("ill_id_pcw", PC_Write, 0);
    chk("ill_id_wrg", Write_Reg, 0);
    chk("ill_id_done", instr_done, 0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'b1;
      #1;
      chk("ill_sticky", illegal, 1);
      chk_quiet("ill");
      chk("ill_instret", instret, exp_instret);
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("ill_rst_clear", illegal, 0);
    chk("ill_rst_instret", instret, 0);
    imem_ready = 1'b0;
    release_reset();

    // reset during EX of addi: discarded, nothing written
    run_instr("pre_rst_j", 0, OP_J, 6'h00, 1'b0, 2, PCS_JMP, 1'b0, WRS_RD, WD_ALU);
    imem_ready = 1'b1;
    #1;
    cyc();
    op = OP_ADDI;
    imem_ready = 1'b0;
    #1;
    chk("abort_id_pcw", PC_Write, 0);
    cyc();
    #1;
    chk("abort_in_ex", dbg_state, ST_EX);
    rst_n = 1'b0;
    #1;
    chk("abort_state", dbg_state, ST_RST);
    chk_quiet("abort");
    chk("abort_instret", instret, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_quiet("abort_hold");
    end
    release_reset();
    chk("abort_final_instret", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
